mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch stage and the data-memory stage.
- Arbitrates between them, sequences the memory request/ready/response handshake, and returns read data to the winner.
- Provides per-requester stall signals that feed the hazard logic, which freezes the PC, IF/ID and the later stages.
- Data has priority over fetch; a starvation guard bounds how long fetch can wait.

Parameters:
- ADDR_W, 64, address width for both requesters and the memory side
- DATA_W, 64, memory and data-port data width; the fetch word is fixed at 32 bits
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits, before fetch is forced

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  ADDR_W  fetch byte address, stable while if_req is high
- if_rdata  out  32  fetched instruction
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  combinational: if_req & ~if_valid
- d_req  in  1  data request, level, held until d_valid
- d_we  in  1  1 = write, 0 = read; stable while d_req is high
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data
- d_valid  out  1  one-cycle data completion pulse (read or write)
- d_stall  out  1  combinational: d_req & ~d_valid
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  memory response (read data or write ack)
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. One transaction outstanding at a time.
- Reset (rst=1 at an edge):
  - state→IDLE, starve_cnt→0, owner→fetch.
  - mem_req, mem_we, if_valid, d_valid → 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata → 0.
  - Reset mid-transaction abandons it. Any later mem_rvalid is ignored.
- IDLE, arbitration:
  - d_req only → grant data.
  - if_req only → grant fetch.
  - Both → grant data, unless starve_cnt==STARVE_LIMIT, in which case grant fetch.
  - On a grant: latch owner, address, we and wdata into registered mem_* outputs; mem_req=1 next cycle; →ISSUE.
  - For a fetch grant mem_we=0 and mem_wdata=0.
  - No request → stay in IDLE.
- starve_cnt update, evaluated on a grant:
  - Data grant with if_req=1 → +1, saturating at STARVE_LIMIT.
  - Fetch grant, or data grant with if_req=0 → 0.
- ISSUE:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant.
  - When mem_ready=1: mem_req→0 next cycle, →WAIT.
  - No timeout.
- WAIT:
  - When mem_rvalid=1, capture the response and →RESP.
  - Fetch owner: if_rdata = mem_rdata[63:32] if the latched addr[2]=1, else mem_rdata[31:0].
  - Data owner, read: d_rdata = mem_rdata.
  - Data owner, write: d_rdata unchanged.
- RESP:
  - Exactly one of if_valid / d_valid is 1, for this cycle only.
  - No arbitration happens in RESP, so a request still held this cycle is not re-granted. →IDLE.
  - The requester must deassert or change its request by the next cycle.
- Ignored inputs:
  - mem_ready outside ISSUE.
  - mem_rvalid outside WAIT.
  - A mem_rvalid coinciding with mem_ready in ISSUE; the response is only accepted in WAIT.
- Latency: minimum 3 cycles from a req sampled in IDLE to the valid pulse:
  - edge 1 → ISSUE, with mem_ready in that cycle;
  - edge 2 → WAIT, with rvalid in that cycle;
  - edge 3 → RESP, valid pulse.
- if_rdata and d_rdata hold their last captured value between transactions.
- Request changes while not yet granted are legal. Changes after grant are a protocol violation; the latched values are used.

Test Plan:
- Reset, then idle: all outputs 0, state IDLE, no mem_req for 10 cycles, even with spurious mem_rvalid=1.
- Single fetch: if_addr=0x104, mem_ready immediate, rvalid one cycle later with mem_rdata=0xAAAA_BBBB_CCCC_DDDD → if_rdata=0xAAAABBBB, if_valid pulses exactly 3 cycles after request, if_stall high until then.
- Simultaneous requests: if_req and d_req(read, 0x40) together → data served first (d_valid), fetch served next; mem_addr sequence 0x40 then fetch address.
- Starvation: if_req held, d_req re-asserted continuously → exactly 4 data grants, then a fetch grant, then data resumes; starve_cnt returns to 0.
- Write with slow memory: d_we=1, d_addr=0x80, d_wdata=0x1234; mem_ready delayed 5 cycles → mem_req/mem_addr/mem_wdata stable all 5 cycles; d_valid pulses after the ack; d_rdata unchanged.
- Reset in WAIT: assert rst for one cycle, then deliver mem_rvalid → no valid pulse, state IDLE, a subsequent fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and the
// data stage: data has priority, and a starvation counter forces fetch after a run of data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned IW = 32;
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [IW-1:0]     if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;

  logic starved_c;
  logic grant_data_c;
  logic grant_fetch_c;

  // Fetch wins a contested cycle only once the data run has hit the limit.
  assign starved_c     = (starve_q == SW'(STARVE_LIMIT));
  assign grant_data_c  = d_req & ~(if_req & starved_c);
  assign grant_fetch_c = if_req & ~grant_data_c;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_data_c) begin
          state_d     = S_ISSUE;
          owner_d     = OWN_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (if_req) begin
            starve_d = starved_c ? starve_q : starve_q + SW'(1);
          end else begin
            starve_d = '0;
          end
        end else if (grant_fetch_c) begin
          state_d     = S_ISSUE;
          owner_d     = OWN_FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end

      S_ISSUE: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end

      // Only a response seen here is accepted; one coinciding with ready is dropped.
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
          if (owner_q == OWN_FETCH) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_addr_q[2] ? mem_rdata[2*IW-1:IW] : mem_rdata[IW-1:0];
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_FETCH;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;

  // Stalls feed the hazard unit in the same cycle.
  assign if_stall = if_req & ~if_valid_q;
  assign d_stall  = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, contention,
// starvation guard, slow write, and reset while a response is outstanding.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_valid;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_stall  (if_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .d_stall   (d_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grants from IDLE, plays the memory side, checks the completion, returns in IDLE.
  task automatic run_grant(input string tag, input logic [63:0] a, input logic we,
                           input logic [63:0] wd, input bit is_data, input int dly,
                           input logic [63:0] rd, input logic [63:0] exp_rd);
    tick();
    check_eq({tag, "_req"}, 64'(mem_req), 64'd1);
    check_eq({tag, "_addr"}, mem_addr, a);
    check_eq({tag, "_we"}, 64'(mem_we), 64'(we));
    check_eq({tag, "_wdata"}, mem_wdata, wd);
    for (int i = 0; i < dly; i++) begin
      tick();
      check_eq({tag, "_hold"}, {63'(mem_req), 1'b0} ^ {mem_addr ^ a} ^ (mem_wdata ^ wd), 64'd2);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_eq({tag, "_req_drop"}, 64'(mem_req), 64'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
    check_eq({tag, "_valids"}, {62'd0, d_valid, if_valid}, is_data ? 64'd2 : 64'd1);
    if (is_data) check_eq({tag, "_drdata"}, d_rdata, exp_rd);
    else         check_eq({tag, "_ifrdata"}, 64'(if_rdata), exp_rd);
    tick();
    check_eq({tag, "_pulse_end"}, {62'd0, d_valid, if_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // reset and quiet idle
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_state", 64'(dut.state_q), 64'd0);
    check_eq("rst_starve", 64'(dut.starve_q), 64'd0);
    check_eq("rst_ctl", {60'd0, mem_req, mem_we, if_valid, d_valid}, 64'd0);
    check_eq("rst_addr", mem_addr, 64'd0);
    check_eq("rst_wdata", mem_wdata, 64'd0);
    check_eq("rst_ifrdata", 64'(if_rdata), 64'd0);
    check_eq("rst_drdata", d_rdata, 64'd0);
    mem_rvalid = 1'b1; mem_ready = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_quiet", {61'd0, mem_req, if_valid, d_valid}, 64'd0);
    end
    mem_rvalid = 1'b0; mem_ready = 1'b0;
    check_eq("idle_state", 64'(dut.state_q), 64'd0);

    // single fetch, explicit latency
    if_req = 1'b1; if_addr = 64'h104;
    #1;
    check_eq("f_stall0", 64'(if_stall), 64'd1);
    tick();
    check_eq("f_req", 64'(mem_req), 64'd1);
    check_eq("f_addr", mem_addr, 64'h104);
    check_eq("f_we", 64'(mem_we), 64'd0);
    check_eq("f_stall1", {62'd0, if_stall, if_valid}, 64'd2);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_eq("f_req_drop", 64'(mem_req), 64'd0);
    check_eq("f_stall2", {62'd0, if_stall, if_valid}, 64'd2);
    mem_rvalid = 1'b1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    mem_rvalid = 1'b0;
    check_eq("f_valid", 64'(if_valid), 64'd1);
    check_eq("f_rdata", 64'(if_rdata), 64'hAAAA_BBBB);
    check_eq("f_stall3", 64'(if_stall), 64'd0);
    check_eq("f_no_dvalid", 64'(d_valid), 64'd0);
    if_req = 1'b0;
    tick();
    check_eq("f_pulse_end", 64'(if_valid), 64'd0);
    check_eq("f_rdata_hold", 64'(if_rdata), 64'hAAAA_BBBB);

    // simultaneous: data first, then fetch
    if_req = 1'b1; if_addr = 64'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
    run_grant("sim_d", 64'h40, 1'b0, 64'd0, 1'b1, 0, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444);
    d_req = 1'b0;
    run_grant("sim_f", 64'h200, 1'b0, 64'd0, 1'b0, 0, 64'h5555_6666_7777_8888, 64'h7777_8888);
    if_req = 1'b0;

    // starvation guard: 4 data grants, forced fetch, data resumes
    if_req = 1'b1; if_addr = 64'h304; d_req = 1'b1; d_addr = 64'h48;
    for (int k = 0; k < 4; k++) begin
      run_grant("stv_d", 64'h48, 1'b0, 64'd0, 1'b1, 0, 64'hD000 + 64'(k), 64'hD000 + 64'(k));
    end
    check_eq("stv_cnt_max", 64'(dut.starve_q), 64'd4);
    run_grant("stv_f", 64'h304, 1'b0, 64'd0, 1'b0, 0, 64'hF00D_CAFE_0000_0001, 64'hF00D_CAFE);
    check_eq("stv_cnt_clr", 64'(dut.starve_q), 64'd0);
    if_req = 1'b0;
    run_grant("stv_d2", 64'h48, 1'b0, 64'd0, 1'b1, 0, 64'hD005, 64'hD005);
    check_eq("stv_cnt_end", 64'(dut.starve_q), 64'd0);
    d_req = 1'b0;

    // write with slow memory; load data register must not move
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h80; d_wdata = 64'h1234;
    run_grant("wr", 64'h80, 1'b1, 64'h1234, 1'b1, 5, 64'hDEAD_BEEF, 64'hD005);
    d_req = 1'b0; d_we = 1'b0;

    // reset while waiting for the response
    if_req = 1'b1; if_addr = 64'h10;
    tick();
    check_eq("rw_req", 64'(mem_req), 64'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_eq("rw_in_wait", 64'(dut.state_q), 64'd2);
    rst = 1'b1; if_req = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("rw_state", 64'(dut.state_q), 64'd0);
    check_eq("rw_outs", {62'd0, mem_req, mem_we}, 64'd0);
    check_eq("rw_ifrdata", 64'(if_rdata), 64'd0);
    check_eq("rw_drdata", d_rdata, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'h9999_9999_9999_9999;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("rw_no_valid", {61'd0, mem_req, d_valid, if_valid}, 64'd0);
    end
    mem_rvalid = 1'b0;
    check_eq("rw_idle", 64'(dut.state_q), 64'd0);
    if_req = 1'b1; if_addr = 64'h10;
    run_grant("rw_f", 64'h10, 1'b0, 64'd0, 1'b0, 0, 64'h1234_5678_9ABC_DEF0, 64'h9ABC_DEF0);
    if_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
